// File: rtl/conv_run_sequencer_if.sv
// ============================================================================
// Module   : conv_run_sequencer_if
// Brief    : Host load stream, core scan/control and drain stream bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface conv_run_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 512
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_weight;
    logic              input_mem_scan_mode;
    logic [1:0]        output_mem_scan_mode;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] data_mem_scan_in;
    logic [DATA_W-1:0] weight_mem_scan_in;
    logic              wen;
    logic              core_reset;
    logic              conv_completed;
    logic [DATA_W-1:0] out1_scan;
    logic [DATA_W-1:0] out2_scan;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  start, in_valid, in_data, in_weight, conv_completed,
               out1_scan, out2_scan, out_ready,
        output in_ready, input_mem_scan_mode, output_mem_scan_mode, scan_addr,
               data_mem_scan_in, weight_mem_scan_in, wen, core_reset,
               out_valid, out_data1, out_data2, out_addr, busy, done, timeout_err
    );

    modport slave (
        output start, in_valid, in_data, in_weight, conv_completed,
               out1_scan, out2_scan, out_ready,
        input  in_ready, input_mem_scan_mode, output_mem_scan_mode, scan_addr,
               data_mem_scan_in, weight_mem_scan_in, wen, core_reset,
               out_valid, out_data1, out_data2, out_addr, busy, done, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/conv_run_sequencer.sv
// ============================================================================
// Module   : conv_run_sequencer
// Brief    : Load / run / wait / drain controller for one Winograd layer run.
//            Optional watchdog in WAIT enabled by macro CONV_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_run_sequencer #(
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    conv_run_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("conv_run_sequencer: illegal DEPTH/ADDR_W/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_WAIT    = 3'd3,
        S_DRAIN_A = 3'd4,
        S_DRAIN_V = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [ADDR_W-1:0] w_scan_addr_next;
    logic              w_accept;
    logic              w_timeout;

    logic              r_in_mode;
    logic [1:0]        r_out_mode;
    logic              r_wen;
    logic              r_core_reset;
    logic              r_out_valid;
    logic              r_done;
    logic              r_busy;
    logic [DATA_W-1:0] r_out_data1;
    logic [DATA_W-1:0] r_out_data2;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic [DATA_W-1:0] r_hold_weight;

    assign w_accept = (r_state == S_LOAD) && bus.in_valid;

`ifdef CONV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_RUN)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;

            if (r_state == S_IDLE && bus.start)
                r_timeout_err <= 1'b0;
            else if (w_timeout && !bus.conv_completed)
                r_timeout_err <= 1'b1;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_timeout       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_scan_addr <= '0;
        end else begin
            r_state     <= w_next;
            r_scan_addr <= w_scan_addr_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_scan_addr_next = r_scan_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next           = S_LOAD;
                    w_scan_addr_next = '0;
                end
            end
            S_LOAD: begin
                // The address parks on the last word so it never wraps.
                if (w_accept) begin
                    if (r_scan_addr == LAST_ADDR)
                        w_next = S_RUN;
                    else
                        w_scan_addr_next = r_scan_addr + 1'b1;
                end
            end
            S_RUN: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.conv_completed) begin
                    w_next           = S_DRAIN_A;
                    w_scan_addr_next = '0;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DRAIN_A: w_next = S_DRAIN_V;
            S_DRAIN_V: begin
                if (bus.out_ready) begin
                    if (r_scan_addr == LAST_ADDR) begin
                        w_next = S_DONE;
                    end else begin
                        w_next           = S_DRAIN_A;
                        w_scan_addr_next = r_scan_addr + 1'b1;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they are registered
    // yet line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_mode    <= 1'b0;
            r_out_mode   <= 2'b00;
            r_wen        <= 1'b0;
            r_core_reset <= 1'b1;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_in_mode    <= (w_next == S_LOAD);
            r_wen        <= (w_next == S_RUN) || (w_next == S_WAIT);
            r_core_reset <= (w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_DONE);
            r_out_valid  <= (w_next == S_DRAIN_V);
            r_done       <= (w_next == S_DONE);
            r_busy       <= (w_next != S_IDLE);
            if ((w_next == S_RUN) || (w_next == S_WAIT))
                r_out_mode <= 2'b01;
            else if ((w_next == S_DRAIN_A) || (w_next == S_DRAIN_V))
                r_out_mode <= 2'b11;
            else
                r_out_mode <= 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data1   <= '0;
            r_out_data2   <= '0;
            r_out_addr    <= '0;
            r_hold_data   <= '0;
            r_hold_weight <= '0;
        end else begin
            if (r_state == S_DRAIN_A) begin
                r_out_data1 <= bus.out1_scan;
                r_out_data2 <= bus.out2_scan;
                r_out_addr  <= r_scan_addr;
            end
            if (w_accept) begin
                r_hold_data   <= bus.in_data;
                r_hold_weight <= bus.in_weight;
            end
        end
    end

    // Accepted words pass straight through; between handshakes the last
    // accepted word is held so the core inputs stay quiet.
    assign bus.in_ready             = (r_state == S_LOAD);
    assign bus.data_mem_scan_in     = w_accept ? bus.in_data   : r_hold_data;
    assign bus.weight_mem_scan_in   = w_accept ? bus.in_weight : r_hold_weight;
    assign bus.input_mem_scan_mode  = r_in_mode;
    assign bus.output_mem_scan_mode = r_out_mode;
    assign bus.scan_addr            = r_scan_addr;
    assign bus.wen                  = r_wen;
    assign bus.core_reset           = r_core_reset;
    assign bus.out_valid            = r_out_valid;
    assign bus.out_data1            = r_out_data1;
    assign bus.out_data2            = r_out_data2;
    assign bus.out_addr             = r_out_addr;
    assign bus.busy                 = r_busy;
    assign bus.done                 = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_run_sequencer.sv
// ============================================================================
// Module   : tb_conv_run_sequencer
// Brief    : Directed bench with a behavioural SRAM/core model around the DUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_run_sequencer;

    localparam int DEPTH = 128;
    localparam int AW    = 8;
    localparam int DW    = 512;
    localparam int TO    = 64;
`ifdef CONV_TIMEOUT_EN
    localparam int WAIT_NOM = 20;
`else
    localparam int WAIT_NOM = 200;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic wipe    = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    always #5 clk = ~clk;

    conv_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    conv_run_sequencer #(
        .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Core model: input SRAMs written on accepted scan words, output SRAM 1/2
    // mirror the data/weight SRAMs and are readable only in drain scan mode.
    logic [DW-1:0] mem_d [1<<AW];
    logic [DW-1:0] mem_w [1<<AW];

    always @(posedge clk) begin
        if (wipe) begin
            for (int k = 0; k < (1 << AW); k++) begin
                mem_d[k] <= '1;
                mem_w[k] <= '1;
            end
        end else if (bus.input_mem_scan_mode && bus.in_valid && bus.in_ready) begin
            mem_d[bus.scan_addr] <= bus.data_mem_scan_in;
            mem_w[bus.scan_addr] <= bus.weight_mem_scan_in;
        end
    end

    assign bus.out1_scan = (bus.output_mem_scan_mode == 2'b11) ? mem_d[bus.scan_addr] : '0;
    assign bus.out2_scan = (bus.output_mem_scan_mode == 2'b11) ? mem_w[bus.scan_addr] : '0;

    function automatic logic [DW-1:0] dval(input int i);
        return DW'(i);
    endfunction

    function automatic logic [DW-1:0] wval(input int i);
        return ~DW'(i);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("load_in_mode", DW'(bus.input_mem_scan_mode), DW'(1));
        check("load_in_ready", DW'(bus.in_ready), DW'(1));
        check("load_addr0", DW'(bus.scan_addr), DW'(0));
        check("load_busy", DW'(bus.busy), DW'(1));
        check("load_core_reset", DW'(bus.core_reset), DW'(1));
        check("load_wen", DW'(bus.wen), DW'(0));
    endtask

    task automatic load(input bit stall, input int count);
        int i = 0;
        int c = 0;
        while (i < count) begin
            if (stall && (c % 3 == 2)) begin
                bus.in_valid = 1'b0;
                #1;
                if (i > 0) check("stall_scan_in_hold", bus.data_mem_scan_in, dval(i - 1));
                tick;
                check("stall_addr_hold", DW'(bus.scan_addr), DW'(i));
            end else begin
                bus.in_valid  = 1'b1;
                bus.in_data   = dval(i);
                bus.in_weight = wval(i);
                #1;
                check("load_addr", DW'(bus.scan_addr), DW'(i));
                check("scan_in_data", bus.data_mem_scan_in, dval(i));
                check("scan_in_weight", bus.weight_mem_scan_in, wval(i));
                tick;
                i++;
            end
            c++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_run(input bit bp, input bit early_cc, input int wait_cyc);
        logic [DW-1:0] h1, h2;
        check("run_wen", DW'(bus.wen), DW'(1));
        check("run_core_reset", DW'(bus.core_reset), DW'(0));
        check("run_out_mode", DW'(bus.output_mem_scan_mode), DW'(1));
        check("run_in_mode", DW'(bus.input_mem_scan_mode), DW'(0));
        check("run_in_ready", DW'(bus.in_ready), DW'(0));
        if (early_cc) bus.conv_completed = 1'b1;
        tick;
        check("wait_wen", DW'(bus.wen), DW'(1));
        check("wait_out_mode", DW'(bus.output_mem_scan_mode), DW'(1));
        if (!early_cc) begin
            bus.start = 1'b1;
            tick;
            bus.start = 1'b0;
            check("ign_start_busy", DW'(bus.busy), DW'(1));
            check("ign_start_wen", DW'(bus.wen), DW'(1));
            check("ign_start_in_mode", DW'(bus.input_mem_scan_mode), DW'(0));
            repeat (wait_cyc) tick;
            check("wait_hold_wen", DW'(bus.wen), DW'(1));
            check("wait_no_valid", DW'(bus.out_valid), DW'(0));
            check("wait_timeout_err", DW'(bus.timeout_err), DW'(0));
            bus.conv_completed = 1'b1;
        end
        tick;
        bus.conv_completed = 1'b0;
        check("drain_a_wen", DW'(bus.wen), DW'(0));
        check("drain_a_mode", DW'(bus.output_mem_scan_mode), DW'(3));
        check("drain_a_valid", DW'(bus.out_valid), DW'(0));
        check("drain_a_addr0", DW'(bus.scan_addr), DW'(0));
        tick;
        check("first_valid_latency", DW'(bus.out_valid), DW'(1));
        for (int a = 0; a < DEPTH; a++) begin
            int n = 0;
            while (bus.out_valid !== 1'b1 && n < 4) begin
                tick;
                n++;
            end
            check("drain_valid", DW'(bus.out_valid), DW'(1));
            check("drain_addr", DW'(bus.out_addr), DW'(a));
            check("drain_data1", bus.out_data1, dval(a));
            check("drain_data2", bus.out_data2, wval(a));
            if (bp && a == 10) begin
                h1 = bus.out_data1;
                h2 = bus.out_data2;
                bus.out_ready = 1'b0;
                repeat (5) begin
                    tick;
                    check("bp_valid", DW'(bus.out_valid), DW'(1));
                    check("bp_addr", DW'(bus.out_addr), DW'(10));
                    check("bp_data1", bus.out_data1, h1);
                    check("bp_data2", bus.out_data2, h2);
                end
                bus.out_ready = 1'b1;
            end
            tick;
            if (a < DEPTH - 1) check("drain_gap", DW'(bus.out_valid), DW'(0));
        end
        check("done_pulse", DW'(bus.done), DW'(1));
        check("done_core_reset", DW'(bus.core_reset), DW'(1));
        check("done_no_valid", DW'(bus.out_valid), DW'(0));
        tick;
        check("done_single", DW'(bus.done), DW'(0));
        check("idle_busy", DW'(bus.busy), DW'(0));
        check("idle_core_reset", DW'(bus.core_reset), DW'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, DW'(bus.busy), DW'(0));
        check({tag, "_core_reset"}, DW'(bus.core_reset), DW'(1));
        check({tag, "_in_ready"}, DW'(bus.in_ready), DW'(0));
        check({tag, "_in_mode"}, DW'(bus.input_mem_scan_mode), DW'(0));
        check({tag, "_out_mode"}, DW'(bus.output_mem_scan_mode), DW'(0));
        check({tag, "_wen"}, DW'(bus.wen), DW'(0));
        check({tag, "_out_valid"}, DW'(bus.out_valid), DW'(0));
        check({tag, "_done"}, DW'(bus.done), DW'(0));
        check({tag, "_timeout_err"}, DW'(bus.timeout_err), DW'(0));
        check({tag, "_scan_addr"}, DW'(bus.scan_addr), DW'(0));
        check({tag, "_out_addr"}, DW'(bus.out_addr), DW'(0));
        check({tag, "_out_data1"}, bus.out_data1, '0);
        check({tag, "_data_scan_in"}, bus.data_mem_scan_in, '0);
        check({tag, "_weight_scan_in"}, bus.weight_mem_scan_in, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        bus.start          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.in_weight      = '0;
        bus.conv_completed = 1'b0;
        bus.out_ready      = 1'b1;

        #12;
        check_reset_values("por");
        reset_n = 1'b1;
        tick;

        // Nominal run with ignored start in WAIT.
        start_run;
        load(1'b0, DEPTH);
        finish_run(1'b0, 1'b0, WAIT_NOM);

        // Stalled load, drain backpressure, completion already high.
        wipe = 1'b1;
        tick;
        wipe = 1'b0;
        start_run;
        load(1'b1, DEPTH);
        finish_run(1'b1, 1'b1, 0);

        // Asynchronous reset part-way through the load.
        wipe = 1'b1;
        tick;
        wipe = 1'b0;
        start_run;
        load(1'b0, 50);
        check("partial_addr", DW'(bus.scan_addr), DW'(50));
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        tick;
        reset_n = 1'b1;
        tick;
        start_run;
        load(1'b0, DEPTH);
        finish_run(1'b0, 1'b0, 10);

`ifdef CONV_TIMEOUT_EN
        begin
            int n;
            start_run;
            load(1'b0, DEPTH);
            tick;
            n = 1;
            while (bus.done !== 1'b1 && n < 4 * TO) begin
                check("wd_no_valid", DW'(bus.out_valid), DW'(0));
                tick;
                n++;
            end
            check("wd_wait_cycles", DW'(n), DW'(TO + 1));
            check("wd_timeout_err", DW'(bus.timeout_err), DW'(1));
            check("wd_done_valid", DW'(bus.out_valid), DW'(0));
            tick;
            check("wd_done_single", DW'(bus.done), DW'(0));
            check("wd_sticky", DW'(bus.timeout_err), DW'(1));
            check("wd_idle", DW'(bus.busy), DW'(0));
            bus.start = 1'b1;
            tick;
            bus.start = 1'b0;
            check("wd_cleared_by_start", DW'(bus.timeout_err), DW'(0));
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
            tick;
        end
`else
        check("final_timeout_err", DW'(bus.timeout_err), DW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_run_sequencer.md
# conv_run_sequencer

Host-side run controller for the Winograd convolution top level. It sequences one complete layer run over a single `clk`:
- streams data/weight words into the input SRAMs through the scan port;
- holds the core in reset while loading, then releases it with write enable asserted;
- waits for `conv_completed`;
- drains both output SRAMs through a valid/ready stream.

It sits between a host interface and the `top` core, replacing hand-driven scan sequencing.

## Interface
Parameters:
- `DEPTH`, 128: words per SRAM loaded and drained.
- `ADDR_W`, 8: scan address width; `DEPTH <= 2**ADDR_W`.
- `DATA_W`, 512: SRAM word width.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in `WAIT`, used only with `CONV_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; accepted only in `IDLE`.
- `in_valid`  in  1  load word valid.
- `in_ready`  out  1  load word accepted.
- `in_data`  in  DATA_W  data SRAM word.
- `in_weight`  in  DATA_W  weight SRAM word.
- `input_mem_scan_mode`  out  1  to core.
- `output_mem_scan_mode`  out  2  to core.
- `scan_addr`  out  ADDR_W  to core.
- `data_mem_scan_in`  out  DATA_W  to core.
- `weight_mem_scan_in`  out  DATA_W  to core.
- `wen`  out  1  to core.
- `core_reset`  out  1  active-high reset to core.
- `conv_completed`  in  1  from core; level.
- `out1_scan`  in  DATA_W  output SRAM 1 read data; valid 1 cycle after `scan_addr`.
- `out2_scan`  in  DATA_W  output SRAM 2 read data; same timing as `out1_scan`.
- `out_valid`  out  1  drain word valid.
- `out_ready`  in  1  drain word accepted.
- `out_data1`  out  DATA_W  drained word, SRAM 1.
- `out_data2`  out  DATA_W  drained word, SRAM 2.
- `out_addr`  out  ADDR_W  address of the current drained word.
- `busy`  out  1  high in every state except `IDLE`.
- `done`  out  1  one-cycle pulse at end of a successful run.
- `timeout_err`  out  1  sticky watchdog flag; cleared by the next `start`.

## Operation
States:
- **IDLE**
  - `core_reset`=1, scan modes 0, `wen`=0, `in_ready`=0.
  - `start` → `LOAD`; clears `timeout_err`; `scan_addr` := 0.
- **LOAD**
  - `input_mem_scan_mode`=1, `in_ready`=1.
  - On `in_valid && in_ready`: `in_data`/`in_weight` drive `*_mem_scan_in` combinationally at the current `scan_addr`; `scan_addr` increments.
  - Acceptance at `scan_addr`=`DEPTH-1` → `RUN`.
  - No handshake: address and core inputs hold; no write side effects are assumed.
- **RUN** (exactly 1 cycle)
  - `input_mem_scan_mode`=0, `core_reset`=0, `output_mem_scan_mode`=01, `wen`=1.
  - → `WAIT`.
- **WAIT**
  - Same outputs as `RUN`.
  - `conv_completed`=1 → `DRAIN_A`; `scan_addr` := 0; `wen` := 0.
- **DRAIN_A**
  - `output_mem_scan_mode`=11; `scan_addr` presented.
  - Next cycle, `out1_scan`/`out2_scan` are captured into the output registers; `out_addr` := `scan_addr` → `DRAIN_V`.
- **DRAIN_V**
  - `out_valid`=1; registers hold until `out_ready`.
  - On handshake at address `DEPTH-1` → `DONE`; otherwise `scan_addr`+1 → `DRAIN_A`.
- **DONE**
  - `done`=1 for 1 cycle; `core_reset`=1 → `IDLE`.

Boundaries:
- `start` while `busy`: ignored.
- `conv_completed` already high on entry to `WAIT`: leave after 1 cycle in `WAIT`.
- `scan_addr` never wraps; terminal-count compares use `DEPTH-1`.
- `reset_n` low mid-run: every state and output returns immediately to reset values. A partially loaded SRAM is not cleared.

## Timing
Reset values (`reset_n` low):
- state `IDLE`;
- `core_reset`=1;
- all scan modes, `wen`, `in_ready`, `out_valid`, `done`, `timeout_err` = 0;
- `scan_addr`, `out_addr`, `out_data*`, `*_scan_in` = 0.

Throughput and latency:
- Load: 1 word/cycle at full `in_valid`. With no stalls, `LOAD` lasts `DEPTH` cycles after the `start` cycle.
- `RUN` → `WAIT`: 1 cycle.
- Drain: 2 cycles per word minimum; first `out_valid` 2 cycles after `conv_completed` is sampled high.
- `done` is asserted the cycle after the last drain handshake.
- All outputs are registered except `in_ready` and `*_mem_scan_in`.

## Configuration
`CONV_TIMEOUT_EN`:
- **Defined:** a counter clears on `RUN` and counts cycles in `WAIT`.
  - It reaching `TIMEOUT_CYCLES-1` without `conv_completed` sets `timeout_err` and goes to `DONE`, skipping drain; `done` still pulses.
  - `conv_completed` and timeout on the same cycle: completion wins.
- **Undefined:** no counter; `WAIT` waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- **Nominal run:** `DEPTH`=128, `start`, 128 back-to-back loads with `in_data`=i, `in_weight`=~i.
  - Expect `scan_addr` 0..127 in `LOAD`, then `RUN` for 1 cycle.
  - Pull `conv_completed` high 200 cycles later.
  - Expect 128 drain words with `out_addr` 0..127 matching the model SRAM contents, then `done` pulsed once.
- **Load stall:** `in_valid` low every third cycle → `scan_addr` holds during gaps; loaded contents are identical to the nominal run.
- **Drain backpressure:** `out_ready` low for 5 cycles at address 10 → `out_valid` and `out_data1`/`out_data2` are stable throughout; no address is skipped or duplicated.
- **Ignored start:** `start` pulsed during `WAIT` → no state change; `busy` stays 1.
- **Async reset:** `reset_n` asserted at load address 50 → all outputs at reset values in the same cycle; a new `start` reloads from address 0.
- **Watchdog:** with `CONV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64, `conv_completed` held 0 → `timeout_err`=1 after 64 `WAIT` cycles, `done` pulses, no `out_valid`.
